muldiv_unit: RTL

//  Multi-cycle RV32M multiply/divide unit; sibling execution unit to the single-cycle ALU in the Otter EX stage.

---
 rtl/otter_pkg.sv | 28 ++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/otter_pkg.sv
// Shared types for the Otter RV32M multiply/divide unit.
package otter_pkg;

  // funct3 encodings of the RV32M instructions
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic op_is_div(input muldiv_op_t o);
    return o[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit. Works on unsigned magnitudes one bit
// per clock (shift-add multiply, restoring divide) and fixes signs at the end.
// Fixed latency: 32 iterations plus one sign-fix cycle plus the done cycle.
module muldiv_unit
  import otter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  md_state_t         state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // mul: {partial product high, multiplier/product low}; div: low word is dividend/quotient
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  // multiplicand for mul, divisor for div (unsigned magnitude; 2^31 fits)
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_t        in_op;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix;

  // Next-state, operand capture, per-bit iteration and final sign correction
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    result_d = result_q;

    in_op = muldiv_op_t'(op);
    a_neg = srcA[XLEN-1] & ((in_op == MULH) || (in_op == MULHSU) ||
                            (in_op == DIV)  || (in_op == REM));
    b_neg = srcB[XLEN-1] & ((in_op == MULH) || (in_op == DIV) || (in_op == REM));
    a_mag = a_neg ? -srcA : srcA;
    b_mag = b_neg ? -srcB : srcB;

    // one shift-add step: add multiplicand when the current multiplier bit is set
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // one restoring step: bring in the next dividend bit and try to subtract
    div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    q_fix    = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    r_fix    = sign_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = in_op;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          div0_d   = (srcB == '0);
          cnt_d    = '0;
          rem_d    = '0;
          if (op_is_div(in_op)) begin
            acc_d  = {{XLEN{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{XLEN{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          state_d = CALC;
        end
      end
      CALC: begin
        if (op_is_div(op_q)) begin
          rem_d             = div_diff[XLEN+1] ? div_shift : div_diff[XLEN:0];
          acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], ~div_diff[XLEN+1]};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        case (op_q)
          MUL:                 result_d = prod_fix[XLEN-1:0];
          MULH, MULHSU, MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          // zero divisor yields all ones regardless of dividend sign
          DIV, DIVU:           result_d = div0_q ? '1 : q_fix;
          REM, REMU:           result_d = r_fix;
          default:             result_d = result_q;
        endcase
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
